alu_result_serializer: RTL and testbench
========================================

# alu_result_serializer

Byte serializer between the ALU result path and the UART transmitter. It captures each registered ALU result, qualified by its valid flag, into a one-entry shadow buffer. It then splits the result into bytes, least-significant byte first, and hands each byte to the UART TX through a valid/busy handshake. The block sits in the system-controller return path and is the consumer of the shift, arithmetic and logic unit outputs.

## Interface
- IN_WIDTH, 16, ALU result width; must be a multiple of 8, minimum 8; NBYTES = IN_WIDTH/8
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  asynchronous, active-low reset
- ALU_OUT  input  IN_WIDTH  ALU result, sampled only when OUT_VALID=1
- OUT_VALID  input  1  one-or-more-cycle valid flag from the ALU; each sampled-high cycle is one result
- TX_BUSY  input  1  UART TX busy; high while a byte is being transmitted
- TX_P_DATA  output  8  byte presented to UART TX
- TX_D_VLD  output  1  TX_P_DATA valid; held until TX_BUSY is sampled high
- SER_BUSY  output  1  high when state≠IDLE or the shadow buffer is full
- OVERRUN  output  1  one-cycle pulse when a result is dropped

## Operation
- Shadow buffer: one IN_WIDTH register plus a full flag. Working register: IN_WIDTH bits. Byte counter: clog2(NBYTES+1) bits.
- Capture: on an edge with OUT_VALID=1, if the shadow is empty, or is being drained on the same edge, write ALU_OUT and set full. Otherwise drop the result and pulse OVERRUN.
- FSM states: IDLE, SEND, WAIT_DONE, plus CHK_SEND and CHK_WAIT when SER_CHECKSUM_EN is defined.
- IDLE: if shadow full, then working←shadow, clear full, counter←0, TX_P_DATA←shadow[7:0], TX_D_VLD←1, go to SEND.
- SEND: hold TX_D_VLD and TX_P_DATA. On TX_BUSY=1: TX_D_VLD←0, go to WAIT_DONE.
- WAIT_DONE: on TX_BUSY=0:
  - if counter<NBYTES-1: counter++, working>>=8, present the next byte with TX_D_VLD←1, go to SEND;
  - otherwise go to IDLE (or CHK_SEND when configured).
- Bytes within a result are sent LSB first. No byte is ever skipped or repeated.
- Resets to: TX_P_DATA=0, TX_D_VLD=0, SER_BUSY=0, OVERRUN=0, state=IDLE, shadow empty, counter=0, checksum=0.
- Reset mid-frame abandons the frame. The UART TX finishes its own byte independently.
- All outputs are registered except SER_BUSY, which is decoded from registered state.

## Timing
- OUT_VALID sampled at edge N → shadow full after N → TX_D_VLD=1 with byte 0 after edge N+1.
- A byte handshake completes when TX_BUSY is sampled high while TX_D_VLD=1. TX_D_VLD falls on that same edge.
- The next byte is presented on the edge that samples TX_BUSY low in WAIT_DONE. Minimum inter-byte gap is 1 cycle after TX_BUSY falls.
- A new result may arrive at any time. It is held in the shadow and begins at most 1 cycle after the current frame returns to IDLE.
- OUT_VALID held high for k cycles counts as k results, subject to overrun.
- TX_BUSY already high in IDLE is ignored; only SEND samples it.

## Configuration
- SER_CHECKSUM_EN defined: after the last data byte, the block sends one extra byte equal to the XOR of all NBYTES data bytes. States CHK_SEND/CHK_WAIT use the same handshake as SEND/WAIT_DONE. The frame is NBYTES+1 bytes.
- SER_CHECKSUM_EN undefined: the frame is exactly NBYTES bytes. No checksum register or states are present.

## Test plan
- Single result: ALU_OUT=16'hA55A, 1-cycle OUT_VALID, TX model busy for 10 cycles per byte → bytes 8'h5A then 8'hA5; SER_BUSY returns to 0 after the second TX_BUSY fall; OVERRUN stays 0.
- Back-to-back: 16'h1234 then 16'h5678 on consecutive cycles → output stream 34,12,78,56 with no gap beyond the 1-cycle minimum.
- Overrun: three results 16'h0001, 16'h0002, 16'h0003 on consecutive cycles with TX_BUSY held high → OVERRUN pulses once, on the third result; stream is 01,00,02,00.
- Handshake hold: TX_BUSY held low for 20 cycles after TX_D_VLD rises → TX_D_VLD and TX_P_DATA=8'h5A remain stable for all 20 cycles.
- Reset mid-frame: assert RST after byte 0 of 16'hBEEF is accepted → all outputs 0 immediately; after release, no residual byte 8'hBE is sent.
- With SER_CHECKSUM_EN: 16'hA55A → bytes 5A, A5, FF; 16'h1234 → 34, 12, 26.

Source files
------------

// File: rtl/alu_result_serializer.sv
// Splits each ALU result into bytes (LSB first) and hands them to the UART TX over a valid/busy handshake.
// Optional trailing XOR checksum byte when SER_CHECKSUM_EN is defined.
module alu_result_serializer #(
  parameter int IN_WIDTH = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [IN_WIDTH-1:0] ALU_OUT,
  input  logic                OUT_VALID,
  input  logic                TX_BUSY,
  output logic [7:0]          TX_P_DATA,
  output logic                TX_D_VLD,
  output logic                SER_BUSY,
  output logic                OVERRUN,
  output logic [2:0]          dbg_state
);

  localparam int NBYTES = IN_WIDTH / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  // Handshake: a byte is transferred on the rising edge where TX_D_VLD=1 and
  // TX_BUSY=1; TX_D_VLD drops on that edge and TX_P_DATA is stable while valid.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_DONE = 3'd2,
    CHK_SEND  = 3'd3,
    CHK_WAIT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] shadow_q, shadow_d;
  logic                full_q, full_d;
  logic [IN_WIDTH-1:0] work_q, work_d;
  logic [IN_WIDTH-1:0] nxt_work;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_vld_q, tx_vld_d;
  logic                ovr_q, ovr_d;
  logic                drain;
`ifdef SER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  assign drain    = (state_q == IDLE) && full_q;
  assign nxt_work = work_q >> 8;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (full_q) state_d = SEND;
      SEND:      if (TX_BUSY) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (cnt_q < LAST_IDX) state_d = SEND;
`ifdef SER_CHECKSUM_EN
          else                  state_d = CHK_SEND;
`else
          else                  state_d = IDLE;
`endif
        end
      end
`ifdef SER_CHECKSUM_EN
      CHK_SEND:  if (TX_BUSY) state_d = CHK_WAIT;
      CHK_WAIT:  if (!TX_BUSY) state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d  = shadow_q;
    full_d    = full_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    ovr_d     = 1'b0;
`ifdef SER_CHECKSUM_EN
    chk_d     = chk_q;
`endif

    // A draining shadow frees its slot on the same edge it is read.
    if (drain) full_d = 1'b0;
    if (OUT_VALID) begin
      if (!full_q || drain) begin
        shadow_d = ALU_OUT;
        full_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q) begin
          work_d    = shadow_q;
          cnt_d     = '0;
          tx_data_d = shadow_q[7:0];
          tx_vld_d  = 1'b1;
`ifdef SER_CHECKSUM_EN
          chk_d     = shadow_q[7:0];
`endif
        end
      end
      SEND: if (TX_BUSY) tx_vld_d = 1'b0;
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (cnt_q < LAST_IDX) begin
            cnt_d     = cnt_q + 1'b1;
            work_d    = nxt_work;
            tx_data_d = nxt_work[7:0];
            tx_vld_d  = 1'b1;
`ifdef SER_CHECKSUM_EN
            chk_d     = chk_q ^ nxt_work[7:0];
`endif
          end else begin
`ifdef SER_CHECKSUM_EN
            tx_data_d = chk_q;
            tx_vld_d  = 1'b1;
`endif
          end
        end
      end
`ifdef SER_CHECKSUM_EN
      CHK_SEND: if (TX_BUSY) tx_vld_d = 1'b0;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shadow_q  <= '0;
      full_q    <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SER_CHECKSUM_EN
      chk_q     <= 8'h00;
`endif
    end else begin
      shadow_q  <= shadow_d;
      full_q    <= full_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      ovr_q     <= ovr_d;
`ifdef SER_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign OVERRUN   = ovr_q;
  assign SER_BUSY  = (state_q != IDLE) || full_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer with a UART TX busy model and byte scoreboard.
// Define SER_CHECKSUM_EN for both files to check the checksum frame.
module tb_alu_result_serializer;

  localparam int BUSY_LEN = 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_VALID = 1'b0;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        SER_BUSY;
  logic        OVERRUN;
  logic [2:0]  dbg_state;

  logic        tx_en = 1'b1;
  logic        force_busy = 1'b0;
  logic        model_busy = 1'b0;
  int          model_cnt = 0;
  int          ovr_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  obs_q[$];
  logic [7:0]  exp_q[$];

  assign TX_BUSY = model_busy | force_busy;

  alu_result_serializer #(.IN_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .SER_BUSY(SER_BUSY), .OVERRUN(OVERRUN), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // TX model and monitor: runs on the falling edge, so TX_BUSY is settled for the next rising edge.
  always @(negedge CLK) begin
    if (model_cnt != 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) model_busy = 1'b0;
    end else if (tx_en && TX_D_VLD && !model_busy) begin
      model_busy = 1'b1;
      model_cnt  = BUSY_LEN;
    end
    if (RST && TX_D_VLD && (model_busy || force_busy)) obs_q.push_back(TX_P_DATA);
    if (OVERRUN) ovr_cnt = ovr_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int n, output bit timed_out);
    int cyc = 0;
    timed_out = 1'b0;
    while (!(obs_q.size() >= n && !SER_BUSY && !TX_D_VLD && !TX_BUSY)) begin
      @(posedge CLK); #1;
      cyc++;
      if (cyc > 2000) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_test();
    obs_q.delete();
    exp_q.delete();
    ovr_cnt = 0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if ({TX_P_DATA, TX_D_VLD, SER_BUSY, OVERRUN, dbg_state} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h vld=%b busy=%b ovr=%b st=%0d, want all 0",
               TX_P_DATA, TX_D_VLD, SER_BUSY, OVERRUN, dbg_state);
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if ({TX_D_VLD, SER_BUSY} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release_idle: got vld=%b busy=%b, want 0 0", TX_D_VLD, SER_BUSY);
    end
  endtask

  task automatic test_single();
    bit to;
    start_test();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
`ifdef SER_CHECKSUM_EN
    exp_q.push_back(8'hFF);
`endif
    ALU_OUT = 16'hA55A; OUT_VALID = 1'b1;
    @(posedge CLK); #1;
    OUT_VALID = 1'b0;
    vectors++;
    if ({SER_BUSY, TX_D_VLD} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_capture: got busy=%b vld=%b, want 1 0", SER_BUSY, TX_D_VLD);
    end
    @(posedge CLK); #1;
    vectors++;
    if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h5A}) begin
      miscompares++;
      $display("FAIL single_first_byte: got vld=%b data=%h, want 1 5a", TX_D_VLD, TX_P_DATA);
    end
    wait_idle(exp_q.size(), to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL single_timeout: got timeout, want idle");
    end
    vectors++;
    if (obs_q !== exp_q) begin
      miscompares++;
      $display("FAIL single_stream: got %p, want %p", obs_q, exp_q);
    end
    vectors++;
    if (ovr_cnt !== 0) begin
      miscompares++;
      $display("FAIL single_overrun: got %0d pulses, want 0", ovr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    start_test();
`ifdef SER_CHECKSUM_EN
    exp_q = '{8'h34, 8'h12, 8'h26, 8'h78, 8'h56, 8'h2E};
`else
    exp_q = '{8'h34, 8'h12, 8'h78, 8'h56};
`endif
    ALU_OUT = 16'h1234; OUT_VALID = 1'b1;
    @(posedge CLK); #1;
    ALU_OUT = 16'h5678;
    @(posedge CLK); #1;
    OUT_VALID = 1'b0;
    wait_idle(exp_q.size(), to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL b2b_timeout: got timeout, want idle");
    end
    vectors++;
    if (obs_q !== exp_q) begin
      miscompares++;
      $display("FAIL b2b_stream: got %p, want %p", obs_q, exp_q);
    end
    vectors++;
    if (ovr_cnt !== 0) begin
      miscompares++;
      $display("FAIL b2b_overrun: got %0d pulses, want 0", ovr_cnt);
    end
  endtask

  task automatic test_overrun();
    bit to;
    start_test();
`ifdef SER_CHECKSUM_EN
    exp_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h00, 8'h02};
`else
    exp_q = '{8'h01, 8'h00, 8'h02, 8'h00};
`endif
    force_busy = 1'b1;
    ALU_OUT = 16'h0001; OUT_VALID = 1'b1;
    @(posedge CLK); #1;
    ALU_OUT = 16'h0002;
    @(posedge CLK); #1;
    vectors++;
    if (OVERRUN !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_second: got %b, want 0", OVERRUN);
    end
    ALU_OUT = 16'h0003;
    @(posedge CLK); #1;
    OUT_VALID = 1'b0;
    vectors++;
    if (OVERRUN !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_third: got %b, want 1", OVERRUN);
    end
    repeat (5) @(posedge CLK);
    #1;
    force_busy = 1'b0;
    wait_idle(exp_q.size(), to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL overrun_timeout: got timeout, want idle");
    end
    vectors++;
    if (obs_q !== exp_q) begin
      miscompares++;
      $display("FAIL overrun_stream: got %p, want %p", obs_q, exp_q);
    end
    vectors++;
    if (ovr_cnt !== 1) begin
      miscompares++;
      $display("FAIL overrun_count: got %0d pulses, want 1", ovr_cnt);
    end
  endtask

  task automatic test_handshake_hold();
    bit to;
    int bad = 0;
    start_test();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
`ifdef SER_CHECKSUM_EN
    exp_q.push_back(8'hFF);
`endif
    tx_en = 1'b0;
    ALU_OUT = 16'hA55A; OUT_VALID = 1'b1;
    @(posedge CLK); #1;
    OUT_VALID = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h5A}) begin
        miscompares++;
        bad++;
        if (bad < 4)
          $display("FAIL hold_cycle_%0d: got vld=%b data=%h, want 1 5a", i, TX_D_VLD, TX_P_DATA);
      end
      @(posedge CLK); #1;
    end
    tx_en = 1'b1;
    wait_idle(exp_q.size(), to);
    vectors++;
    if (to || obs_q !== exp_q) begin
      miscompares++;
      $display("FAIL hold_stream: got %p timeout=%b, want %p", obs_q, to, exp_q);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0;
    start_test();
    ALU_OUT = 16'hBEEF; OUT_VALID = 1'b1;
    @(posedge CLK); #1;
    OUT_VALID = 1'b0;
    while (obs_q.size() < 1 && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
    end
    @(posedge CLK); #1;
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== 8'hEF) begin
      miscompares++;
      $display("FAIL midrst_byte0: got %p, want '{ef}", obs_q);
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if ({TX_P_DATA, TX_D_VLD, SER_BUSY, OVERRUN, dbg_state} !== 14'h0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got data=%h vld=%b busy=%b ovr=%b st=%0d, want all 0",
               TX_P_DATA, TX_D_VLD, SER_BUSY, OVERRUN, dbg_state);
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    vectors++;
    if (obs_q.size() != 1 || SER_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_residual: got %p busy=%b, want '{ef} busy=0", obs_q, SER_BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_handshake_hold();
    test_reset_mid_frame();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
